// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline hazard controller.
//
// Contents
//   RA_W_DEF   default register address width
//   RA_W_MAX   widest register address an entry can hold
//   STG_*      stage index constants for the tracked stages after ID
//   entry_t    per-stage tracking record {valid, we, rd, load}
//   sel_width  width of one forward select for a given stage count
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int RA_W_DEF = 5;

  // The entry type has to be fixed at package level.
  // rd is therefore sized for the widest supported register file.
  // Narrower address widths are zero-extended on the way in.
  // Register 0 still compares as zero, and upper bits never create false matches.
  localparam int RA_W_MAX = 8;

  // Stage indices, counted from the youngest tracked stage.
  localparam int STG_EXE = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // Forward select encoding: 0 reads the regfile, i+1 forwards from stage i.
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic [RA_W_MAX-1:0] rd;
    logic                load;
  } entry_t;

  // One code per tracked stage plus the regfile code.
  function automatic int sel_width(input int n_stage);
    return $clog2(n_stage + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_match.sv
// ---------------------------------------------------------------------------
// hazard_match
// Priority comparator for one ID source operand.
// It compares the operand against every tracked stage entry.
// It reports the youngest stage that will write the register.
//
// Ports
//   i_entries   in   tracked stage entries, index 0 = youngest (EXE)
//   i_src_addr  in   source register address, zero-extended to RA_W_MAX
//   i_src_use   in   source is really read from the regfile
//   o_hit       out  some tracked stage will write this source register
//   o_hit_idx   out  index of the youngest matching stage
//   o_load_hit  out  that youngest producer is a load
// ---------------------------------------------------------------------------
module hazard_match
  import pipe_pkg::*;
#(
  parameter int N_STAGE = 3,
  parameter int SEL_W   = 2
) (
  input  entry_t [N_STAGE-1:0]  i_entries,
  input  logic   [RA_W_MAX-1:0] i_src_addr,
  input  logic                  i_src_use,
  output logic                  o_hit,
  output logic   [SEL_W-1:0]    o_hit_idx,
  output logic                  o_load_hit
);

  // Walk from the oldest stage towards the youngest.
  // A later assignment overrides an earlier one, so the lowest matching index wins.
  // That stage holds the most recent value of the register.
  // A register-0 destination is never a producer, because r0 is hard-wired.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_idx  = '0;
    o_load_hit = 1'b0;
    for (int i = N_STAGE - 1; i >= 0; i--) begin
      if (i_entries[i].valid && i_entries[i].we && (i_entries[i].rd != '0) &&
          (i_entries[i].rd == i_src_addr) && i_src_use) begin
        o_hit      = 1'b1;
        o_hit_idx  = SEL_W'(i);
        o_load_hit = i_entries[i].load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// RAW-hazard, bypass-select and stall controller for the in-order pipeline.
// It sits beside ID.
//
// It keeps a shift register of destination-register state, one entry per stage
// after ID. For each ID source operand it chooses one of three actions:
// read the regfile, forward from a later stage, or stall ID.
//
// Parameters
//   N_STAGE   tracked stages after ID (0=EXE ... N_STAGE-1=WB)
//   RA_W      register address width (at most RA_W_MAX)
//   N_SRC     ID source operands checked
//   FWD_EN    0 = stall on any match, 1 = forward and stall only on load-use
//   LOAD_RDY  lowest stage index whose load result can be forwarded
//
// Ports
//   clk          in   clock, rising edge
//   resetn       in   asynchronous active-low reset
//   id_valid     in   ID holds a valid instruction
//   id_rf_we     in   ID instruction writes the regfile
//   id_rd        in   ID destination register
//   id_is_load   in   ID instruction takes its result from data RAM
//   id_src_addr  in   source addresses, src s at [s*RA_W +: RA_W]
//   id_src_use   in   source s is really read
//   id_br_taken  in   ID branch/jump resolved taken
//   pipe_hold    in   external stall, freezes every tracked stage
//   flush        in   kill every tracked stage and the ID instruction
//   id_ready_go  out  ID may issue into EXE this cycle
//   exe_in_valid out  valid bit presented to the EXE pipeline register
//   if_cancel    out  IF instruction must become a bubble
//   fwd_sel      out  per source: 0 = regfile, i+1 = forward from stage i
//   stage_valid  out  valid bit of each tracked stage
//   stall_cnt    out  saturating count of hazard stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int N_STAGE  = 3,
  parameter int RA_W     = RA_W_DEF,
  parameter int N_SRC    = 2,
  parameter int FWD_EN   = 1,
  parameter int LOAD_RDY = STG_WB,
  localparam int SEL_W   = sel_width(N_STAGE)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   id_valid,
  input  logic                   id_rf_we,
  input  logic [RA_W-1:0]        id_rd,
  input  logic                   id_is_load,
  input  logic [N_SRC*RA_W-1:0]  id_src_addr,
  input  logic [N_SRC-1:0]       id_src_use,
  input  logic                   id_br_taken,
  input  logic                   pipe_hold,
  input  logic                   flush,
  output logic                   id_ready_go,
  output logic                   exe_in_valid,
  output logic                   if_cancel,
  output logic [N_SRC*SEL_W-1:0] fwd_sel,
  output logic [N_STAGE-1:0]     stage_valid,
  output logic [15:0]            stall_cnt
);

  entry_t [N_STAGE-1:0] r_entries;
  logic   [15:0]        r_stall_cnt;

  logic [RA_W_MAX-1:0]  w_src_ext [N_SRC];
  logic [N_SRC-1:0]     w_hit;
  logic [N_SRC-1:0]     w_load_hit;
  logic [SEL_W-1:0]     w_hit_idx [N_SRC];
  logic                 w_hazard;
  logic [N_SRC*SEL_W-1:0] w_fwd_sel;
  logic                 w_ready_go;
  logic                 w_exe_in_valid;
  entry_t               w_new_entry;

  // Widen each source address to the entry's rd width.
  // The comparators can then work on a single address type.
  always_comb begin
    for (int s = 0; s < N_SRC; s++) begin
      w_src_ext[s]           = '0;
      w_src_ext[s][RA_W-1:0] = id_src_addr[s*RA_W +: RA_W];
    end
  end

  // One priority comparator per source operand.
  // Each one reports the youngest in-flight producer of that operand.
  for (genvar s = 0; s < N_SRC; s++) begin : g_src
    hazard_match #(
      .N_STAGE (N_STAGE),
      .SEL_W   (SEL_W)
    ) u_match (
      .i_entries  (r_entries),
      .i_src_addr (w_src_ext[s]),
      .i_src_use  (id_src_use[s]),
      .o_hit      (w_hit[s]),
      .o_hit_idx  (w_hit_idx[s]),
      .o_load_hit (w_load_hit[s])
    );
  end

  // Turn each source's youngest match into a stall or a bypass select.
  // With forwarding off, any match stalls and the selects stay on the regfile.
  // With forwarding on, only a load that has not reached LOAD_RDY stalls.
  // Every other match forwards, including a match in WB.
  // WB must forward because the regfile write lands at the same edge as the ID read.
  always_comb begin
    w_hazard  = 1'b0;
    w_fwd_sel = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (w_hit[s]) begin
        if (FWD_EN == 0) begin
          w_hazard = 1'b1;
        end else if (w_load_hit[s] && (int'(w_hit_idx[s]) < LOAD_RDY)) begin
          w_hazard = 1'b1;
        end else begin
          w_fwd_sel[s*SEL_W +: SEL_W] = w_hit_idx[s] + SEL_W'(1);
        end
      end
    end
  end

  // Issue control is purely combinational, so ID learns in the same cycle
  // whether it may issue.
  // A taken branch cancels IF only when it actually issues. A stalled branch
  // re-resolves next cycle, so its fetch-side effect must wait until then.
  always_comb begin
    w_ready_go     = ~flush & ~pipe_hold & ~w_hazard;
    w_exe_in_valid = id_valid & w_ready_go;
  end

  // The record for the instruction entering EXE.
  // On a stall its valid bit is 0, which forms the bubble.
  always_comb begin
    w_new_entry                = '0;
    w_new_entry.valid          = w_exe_in_valid;
    w_new_entry.we             = id_rf_we;
    w_new_entry.rd[RA_W-1:0]   = id_rd;
    w_new_entry.load           = id_is_load;
  end

  // Stage tracking shift register.
  // Flush beats hold: a flush clears only the valid bits, because the other
  // fields are ignored while an entry is invalid.
  // Hold freezes every stage.
  // Otherwise everything shifts one stage older and the WB entry drops off.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_entries <= '0;
    end else if (flush) begin
      for (int i = 0; i < N_STAGE; i++) begin
        r_entries[i].valid <= 1'b0;
      end
    end else if (!pipe_hold) begin
      r_entries[STG_EXE] <= w_new_entry;
      for (int i = 1; i < N_STAGE; i++) begin
        r_entries[i] <= r_entries[i-1];
      end
    end
  end

  // Hazard stall counter, for performance monitoring.
  // It counts only cycles lost to a data hazard.
  // Held or flushed cycles are charged elsewhere, so they are not counted here.
  // The counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (id_valid && w_hazard && !pipe_hold && !flush &&
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Expose the per-stage valid bits for debug and for downstream kill logic.
  always_comb begin
    for (int i = 0; i < N_STAGE; i++) begin
      stage_valid[i] = r_entries[i].valid;
    end
  end

  assign id_ready_go  = w_ready_go;
  assign exe_in_valid = w_exe_in_valid;
  assign if_cancel    = id_valid & id_br_taken & w_ready_go;
  assign fwd_sel      = w_fwd_sel;
  assign stall_cnt    = r_stall_cnt;

endmodule
